// File: rtl/soc_bus_responder.sv
// Memory-side responder for the RV32IM core: shared word RAM on both ports plus a
// small MMIO window with a byte TX FIFO, a status register and a cycle counter.
module soc_bus_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_mem_rw_i,
    output logic [31:0] data_rdata_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   ram [MEM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycle;

    logic          data_ram;
    logic          data_mmio;
    logic          inst_ram;
    logic [AW-1:0] data_idx;
    logic [AW-1:0] inst_idx;
    logic [11:0]   offset;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          ovf_set;
    logic          ovf_clr;
    logic [31:0]   status;
    logic          unused_inst_bits;

    assign data_ram  = data_addr_i[31:28] == 4'h0;
    assign data_mmio = data_addr_i[31:12] == MMIO_BASE[31:12];
    assign offset    = data_addr_i[11:0];
    assign data_idx  = data_addr_i[2 +: AW];
    assign inst_ram  = inst_addr_i[31:28] == 4'h0;
    assign inst_idx  = inst_addr_i[2 +: AW];
    assign unused_inst_bits = ^{inst_addr_i[1:0], inst_addr_i[27:2+AW]};

    assign full       = count == CW'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign tx_valid_o = !empty;
    assign tx_data_o  = fifo_mem[rd_ptr];
    assign pop        = tx_valid_o && tx_ready_i;

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign push_req = data_mem_rw_i && data_mmio && (offset == 12'h000);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = data_mem_rw_i && data_mmio && (offset == 12'h004) && data_wdata_i[2];

    assign status = {16'h0000, 8'(count), 5'b00000, overflow, empty, full};

    always_comb begin
        data_rdata_o = 32'h0000_0000;
        if (data_ram) begin
            data_rdata_o = ram[data_idx];
        end else if (data_mmio) begin
            case (offset)
                12'h004: data_rdata_o = status;
                12'h008: data_rdata_o = cycle;
                default: data_rdata_o = 32'h0000_0000;
            endcase
        end
    end

    assign inst_data_o = inst_ram ? ram[inst_idx] : 32'h0000_0013;

    // RAM is never reset; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (data_mem_rw_i && data_ram && !reset) begin
            ram[data_idx] <= data_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cycle    <= 32'h0000_0000;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 8'h00;
            end
        end else begin
            cycle <= cycle + 32'd1;
            if (push_ok) begin
                fifo_mem[wr_ptr] <= data_wdata_i[7:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_soc_bus_responder.sv
// Bench for soc_bus_responder: fixed vector table, hand-written FIFO/reset sequences
// and a randomized run against a queue-based reference model.
module tb_soc_bus_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst_addr_i = 32'h2000_0000;
    logic [31:0] inst_data_o;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_mem_rw_i = 1'b0;
    logic [31:0] data_rdata_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;

    always #5 clk = ~clk;

    soc_bus_responder #(.MEM_WORDS(1024), .FIFO_DEPTH(8), .MMIO_BASE(32'h1000_0000)) dut (
        .clk(clk), .reset(reset),
        .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_mem_rw_i(data_mem_rw_i), .data_rdata_o(data_rdata_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
    );

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [31:0] ram_m [int];
    logic [7:0]  q [$];
    bit          ovf_m = 1'b0;
    int unsigned cyc_m = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic        ready;
        logic [31:0] iaddr;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_in;
        logic        exp_valid;
        logic [7:0]  exp_tx;
    } vec_t;

    vec_t vt [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(q.size()) << 8;
        if (ovf_m) s = s | 32'h4;
        if (q.size() == 0) s = s | 32'h2;
        if (q.size() == 8) s = s | 32'h1;
        return s;
    endfunction

    function automatic bit m_is_mmio(input logic [31:0] a);
        return a[31:12] == 20'h10000;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic rw,
                         input logic rdy, input logic [31:0] ia);
        data_addr_i   = a;
        data_wdata_i  = w;
        data_mem_rw_i = rw;
        tx_ready_i    = rdy;
        inst_addr_i   = ia;
        #1;
    endtask

    // Applies the effect of the current inputs to the model, then crosses one edge.
    task automatic step();
        bit full, pop, push, clr, set;
        if (data_mem_rw_i && data_addr_i[31:28] == 4'h0)
            ram_m[int'(data_addr_i[11:2])] = data_wdata_i;
        full = q.size() == 8;
        pop  = q.size() > 0 && tx_ready_i;
        push = data_mem_rw_i && m_is_mmio(data_addr_i) && data_addr_i[11:0] == 12'h000;
        clr  = data_mem_rw_i && m_is_mmio(data_addr_i) && data_addr_i[11:0] == 12'h004 && data_wdata_i[2];
        set  = push && full && !pop;
        if (pop) void'(q.pop_front());
        if (push && !set) q.push_back(data_wdata_i[7:0]);
        if (set) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        cyc_m++;
        @(posedge clk);
        #1;
    endtask

    task automatic compare_now(input string tag);
        logic [31:0] a;
        a = data_addr_i;
        if (a[31:28] == 4'h0) begin
            if (ram_m.exists(int'(a[11:2]))) check({tag, " ram rdata"}, data_rdata_o, ram_m[int'(a[11:2])]);
        end else if (m_is_mmio(a)) begin
            if (a[11:0] == 12'h004) check({tag, " status"}, data_rdata_o, m_status());
            else if (a[11:0] == 12'h008) check({tag, " cycle"}, data_rdata_o, cyc_m);
            else check({tag, " mmio zero"}, data_rdata_o, 32'h0);
        end else begin
            check({tag, " unmapped"}, data_rdata_o, 32'h0);
        end
        if (inst_addr_i[31:28] != 4'h0) check({tag, " nop fetch"}, inst_data_o, 32'h13);
        else if (ram_m.exists(int'(inst_addr_i[11:2])))
            check({tag, " fetch"}, inst_data_o, ram_m[int'(inst_addr_i[11:2])]);
        check({tag, " valid"}, 32'(tx_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, " tx_data"}, 32'(tx_data_o), 32'(q[0]));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        data_mem_rw_i = 1'b0;
        tx_ready_i = 1'b0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        cyc_m = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drain [8];
        vt[0]  = '{32'h1000_0004, 32'h0,         1'b0, 1'b0, 32'h2000_0000, 1'b1, 32'h2,         32'h13,        1'b0, 8'h00};
        vt[1]  = '{32'h0000_0010, 32'h1111_1111, 1'b1, 1'b0, 32'h2000_0000, 1'b0, 32'h0,         32'h13,        1'b0, 8'h00};
        vt[2]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h1111_1111, 32'h1111_1111, 1'b0, 8'h00};
        vt[3]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 8'h00};
        vt[4]  = '{32'h0000_1004, 32'h1234_5678, 1'b1, 1'b0, 32'h2000_0000, 1'b0, 32'h0,         32'h13,        1'b0, 8'h00};
        vt[5]  = '{32'h0000_0004, 32'h0,         1'b0, 1'b0, 32'h0000_1004, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 8'h00};
        vt[6]  = '{32'h1000_0000, 32'h41,        1'b1, 1'b0, 32'h2000_0000, 1'b1, 32'h0,         32'h13,        1'b0, 8'h00};
        vt[7]  = '{32'h1000_0000, 32'h42,        1'b1, 1'b0, 32'h2000_0000, 1'b1, 32'h0,         32'h13,        1'b1, 8'h41};
        vt[8]  = '{32'h1000_0000, 32'h43,        1'b1, 1'b0, 32'h2000_0000, 1'b1, 32'h0,         32'h13,        1'b1, 8'h41};
        vt[9]  = '{32'h1000_0004, 32'h0,         1'b0, 1'b0, 32'h2000_0000, 1'b1, 32'h300,       32'h13,        1'b1, 8'h41};
        vt[10] = '{32'h1000_0008, 32'h0,         1'b0, 1'b0, 32'h2000_0000, 1'b1, 32'd10,        32'h13,        1'b1, 8'h41};
        vt[11] = '{32'h1000_000C, 32'h0,         1'b0, 1'b1, 32'h2000_0000, 1'b1, 32'h0,         32'h13,        1'b1, 8'h41};
        vt[12] = '{32'h3000_0000, 32'h0,         1'b0, 1'b1, 32'h2000_0000, 1'b1, 32'h0,         32'h13,        1'b1, 8'h42};
        vt[13] = '{32'h1000_0004, 32'h0,         1'b0, 1'b1, 32'h2000_0000, 1'b1, 32'h100,       32'h13,        1'b1, 8'h43};
        vt[14] = '{32'h1000_0004, 32'h0,         1'b0, 1'b0, 32'h2000_0000, 1'b1, 32'h2,         32'h13,        1'b0, 8'h00};
        vt[15] = '{32'h3000_0010, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h2000_0000, 1'b1, 32'h0,         32'h13,        1'b0, 8'h00};
        vt[16] = '{32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hF000_0010, 1'b1, 32'hDEAD_BEEF, 32'h13,        1'b0, 8'h00};
        vt[17] = '{32'h1000_0008, 32'h0,         1'b1, 1'b0, 32'h2000_0000, 1'b1, 32'd17,        32'h13,        1'b0, 8'h00};
        vt[18] = '{32'h1000_0008, 32'h0,         1'b0, 1'b0, 32'h2000_0000, 1'b1, 32'd18,        32'h13,        1'b0, 8'h00};
        drain = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h60};

        do_reset();

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].addr, vt[i].wdata, vt[i].rw, vt[i].ready, vt[i].iaddr);
            if (vt[i].chk_rd) check($sformatf("vec%0d rdata", i), data_rdata_o, vt[i].exp_rd);
            check($sformatf("vec%0d inst", i), inst_data_o, vt[i].exp_in);
            check($sformatf("vec%0d valid", i), 32'(tx_valid_o), 32'(vt[i].exp_valid));
            if (vt[i].exp_valid || i == 0)
                check($sformatf("vec%0d tx_data", i), 32'(tx_data_o), 32'(vt[i].exp_tx));
            step();
        end

        // overflow, sticky clear, push+pop while full
        for (int b = 0; b < 9; b++) begin
            drive(32'h1000_0000, 32'h50 + 32'(b), 1'b1, 1'b0, 32'h2000_0000);
            step();
        end
        drive(32'h1000_0004, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
        check("ovf status", data_rdata_o, 32'h805);
        drive(32'h1000_0004, 32'h4, 1'b1, 1'b0, 32'h2000_0000);
        step();
        drive(32'h1000_0004, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
        check("ovf cleared", data_rdata_o, 32'h801);
        drive(32'h1000_0000, 32'h60, 1'b1, 1'b1, 32'h2000_0000);
        check("full head", 32'(tx_data_o), 32'h50);
        step();
        drive(32'h1000_0004, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
        check("push+pop full status", data_rdata_o, 32'h801);
        for (int k = 0; k < 8; k++) begin
            drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h2000_0000);
            check($sformatf("drain%0d valid", k), 32'(tx_valid_o), 32'h1);
            check($sformatf("drain%0d data", k), 32'(tx_data_o), 32'(drain[k]));
            step();
        end
        drive(32'h1000_0004, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
        check("drained valid", 32'(tx_valid_o), 32'h0);
        check("drained status", data_rdata_o, 32'h2);

        // CYCLE after reset and read purity
        do_reset();
        for (int k = 0; k < 100; k++) begin
            drive(32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
            step();
        end
        drive(32'h1000_0008, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
        check("cycle 100", data_rdata_o, 32'd100);
        for (int b = 0; b < 3; b++) begin
            drive(32'h1000_0000, 32'h71 + 32'(b), 1'b1, 1'b0, 32'h2000_0000);
            step();
        end
        for (int k = 0; k < 1000; k++) begin
            drive((k % 2 == 0) ? 32'h1000_0000 : 32'h1000_0004, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h2000_0000);
            step();
        end
        drive(32'h1000_0004, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
        check("purity status", data_rdata_o, 32'h300);
        check("purity head", 32'(tx_data_o), 32'h71);
        drive(32'h1000_0008, 32'h0, 1'b0, 1'b0, 32'h2000_0000);
        check("purity cycle", data_rdata_o, 32'd1103);

        // reset while draining 5 queued bytes
        for (int b = 0; b < 2; b++) begin
            drive(32'h1000_0000, 32'h74 + 32'(b), 1'b1, 1'b0, 32'h2000_0000);
            step();
        end
        drive(32'h1000_0008, 32'h0, 1'b0, 1'b1, 32'h2000_0000);
        check("predrain valid", 32'(tx_valid_o), 32'h1);
        check("predrain status", q.size() == 5 ? 32'h1 : 32'h0, 32'h1);
        step();
        drive(32'h1000_0008, 32'h0, 1'b0, 1'b1, 32'h2000_0000);
        reset = 1'b1;
        #1;
        check("rst valid", 32'(tx_valid_o), 32'h0);
        check("rst tx_data", 32'(tx_data_o), 32'h0);
        check("rst cycle", data_rdata_o, 32'h0);
        reset = 1'b0;
        tx_ready_i = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        cyc_m = 0;
        #1;

        // randomized traffic against the model
        for (int w = 0; w < 16; w++) begin
            drive(32'((40 + w) * 4), $urandom, 1'b1, 1'b0, 32'h2000_0000);
            step();
        end
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, ia;
            logic rw;
            int op;
            op = $urandom_range(0, 9);
            rw = 1'($urandom_range(0, 1));
            case (op)
                0, 1, 2: a = {4'h0, 16'($urandom), 10'(40 + $urandom_range(0, 15)), 2'($urandom)};
                3, 4: begin a = 32'h1000_0000; rw = 1'b1; end
                5: a = 32'h1000_0004;
                6: a = 32'h1000_0008;
                7: a = {20'h10000, 12'($urandom)};
                8: a = {4'($urandom_range(2, 15)), 28'($urandom)};
                default: begin a = 32'h1000_0000; rw = 1'b0; end
            endcase
            if ($urandom_range(0, 1) == 1) ia = {4'h0, 16'($urandom), 10'(40 + $urandom_range(0, 15)), 2'($urandom)};
            else ia = {4'($urandom_range(1, 15)), 28'($urandom)};
            drive(a, $urandom, rw, ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, ia);
            compare_now($sformatf("rnd%0d", n));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
